// File: rtl/cordic_rot_ctrl_if.sv
// Request/result and LUT-access signals of the iterative CORDIC rotation engine.
interface cordic_rot_ctrl_if;
  logic               start;
  logic signed [31:0] angle_in;
  logic               busy;
  logic               done;
  logic signed [31:0] cos_out;
  logic signed [31:0] sin_out;
  logic        [4:0]  lut_i;
  logic        [31:0] lut_xita;

  modport master (
    output start, angle_in, lut_xita,
    input  busy, done, cos_out, sin_out, lut_i
  );

  modport slave (
    input  start, angle_in, lut_xita,
    output busy, done, cos_out, sin_out, lut_i
  );
endinterface

// File: rtl/cordic_rot_ctrl.sv
// Iterative CORDIC rotation engine: one LUT fetch + one micro-rotation per iteration, Q2.30 cos/sin.
// Optional +/-180 degree quadrant pre-rotation enabled by macro CORDIC_ROT_CTRL_QUAD_EN.
module cordic_rot_ctrl #(
  parameter int                 ITER   = 16,
  parameter logic signed [31:0] K_INIT = 32'sd652032874
) (
  input  logic            clk,
  input  logic            rst,
  cordic_rot_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FETCH, ROT, DONE} state_t;

  localparam logic [4:0] LAST = 5'(ITER - 1);

  state_t             state_q, state_d;
  logic signed [31:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic signed [31:0] cos_q, cos_d, sin_q, sin_d;
  logic        [4:0]  i_q, i_d;
  logic signed [31:0] x_rot, y_rot, z_rot, xs, ys, xita;
  logic               unused_xita_msb;
`ifdef CORDIC_ROT_CTRL_QUAD_EN
  localparam logic signed [31:0] DEG90  = 32'sd5898240;
  localparam logic signed [31:0] DEG180 = 32'sd11796480;
  logic               neg_q, neg_d;
`endif

  assign unused_xita_msb = bus.lut_xita[31];

  // Micro-rotation datapath: direction follows the sign of the residual angle
  always_comb begin
    xs   = x_q >>> i_q;
    ys   = y_q >>> i_q;
    xita = {1'b0, bus.lut_xita[30:0]};
    if (!z_q[31]) begin
      x_rot = x_q - ys;
      y_rot = y_q + xs;
      z_rot = z_q - xita;
    end else begin
      x_rot = x_q + ys;
      y_rot = y_q - xs;
      z_rot = z_q + xita;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    i_d     = i_q;
    cos_d   = cos_q;
    sin_d   = sin_q;
`ifdef CORDIC_ROT_CTRL_QUAD_EN
    neg_d   = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          x_d     = K_INIT;
          y_d     = '0;
          z_d     = bus.angle_in;
          i_d     = '0;
          state_d = FETCH;
`ifdef CORDIC_ROT_CTRL_QUAD_EN
          neg_d   = 1'b0;
          if (bus.angle_in > DEG90) begin
            z_d   = bus.angle_in - DEG180;
            neg_d = 1'b1;
          end else if (bus.angle_in < -DEG90) begin
            z_d   = bus.angle_in + DEG180;
            neg_d = 1'b1;
          end
`endif
        end
      end
      FETCH: state_d = ROT;
      ROT: begin
        x_d = x_rot;
        y_d = y_rot;
        z_d = z_rot;
        if (i_q == LAST) begin
          state_d = DONE;
`ifdef CORDIC_ROT_CTRL_QUAD_EN
          cos_d   = neg_q ? -x_rot : x_rot;
          sin_d   = neg_q ? -y_rot : y_rot;
`else
          cos_d   = x_rot;
          sin_d   = y_rot;
`endif
        end else begin
          i_d     = i_q + 5'd1;
          state_d = FETCH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Results are latched on the edge entering DONE, so they are valid with the done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
      cos_q   <= '0;
      sin_q   <= '0;
`ifdef CORDIC_ROT_CTRL_QUAD_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      i_q     <= i_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
`ifdef CORDIC_ROT_CTRL_QUAD_EN
      neg_q   <= neg_d;
`endif
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.cos_out = cos_q;
  assign bus.sin_out = sin_q;
  assign bus.lut_i   = (state_q == IDLE) ? 5'd0 : i_q;

endmodule

// File: tb/tb_cordic_rot_ctrl.sv
// Scoreboard bench for cordic_rot_ctrl: arctan LUT model, cycle-level busy/done model, trig reference.
module tb_cordic_rot_ctrl;
  localparam int    ITER   = 16;
  localparam int    TOL    = 1 << 17;
  localparam int    DEG    = 65536;
  localparam real   PI     = 3.141592653589793;

  typedef struct {
    longint c;
    longint s;
    bit     v;
  } exp_t;

  logic clk;
  logic rst;
  cordic_rot_ctrl_if bus();

  cordic_rot_ctrl #(.ITER(ITER)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   lut_tab [32];
  int   model_cnt = 0;
  bit   lut_chk = 0;
  exp_t sb [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input longint obs, input longint exp, input longint tol);
    longint diff;
    checks++;
    diff = (obs > exp) ? obs - exp : exp - obs;
    if (diff > tol) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d tol=%0d", tag, obs, exp, tol);
    end
  endtask

  function automatic longint rnd(input real r);
    if (r >= 0.0) return longint'($rtoi(r + 0.5));
    else          return -longint'($rtoi(-r + 0.5));
  endfunction

  function automatic exp_t exp_of(input logic signed [31:0] a);
    exp_t e;
    real  rad;
    rad = (real'(a) / real'(DEG)) * PI / 180.0;
    e.c = rnd($cos(rad) * 1073741824.0);
    e.s = rnd($sin(rad) * 1073741824.0);
`ifdef CORDIC_ROT_CTRL_QUAD_EN
    e.v = 1'b1;
`else
    e.v = (a <= 90 * DEG) && (a >= -90 * DEG);
`endif
    return e;
  endfunction

  // atan(2^-i) in 16.16 degrees; bit 31 deliberately set on odd indices since the DUT must ignore it
  initial begin
    for (int i = 0; i < 32; i++)
      lut_tab[i] = (i <= 20) ? int'(rnd($atan(2.0 ** (-i)) * 180.0 / PI * real'(DEG))) : 0;
  end

  always @(posedge clk) begin
    logic [31:0] v;
    v = lut_tab[bus.lut_i];
    bus.lut_xita <= {bus.lut_i[0], v[30:0]};
  end

  // Reference sequencer: accept in idle, busy for 2*ITER+1 cycles, done in the last of them
  always @(posedge clk) begin
    if (rst) begin
      model_cnt <= 0;
      sb.delete();
    end else if (model_cnt == 0) begin
      if (bus.start) begin
        model_cnt <= 2 * ITER + 1;
        sb.push_back(exp_of(bus.angle_in));
      end
    end else begin
      model_cnt <= model_cnt - 1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check_val("busy", longint'(bus.busy), longint'(model_cnt != 0), 0);
      check_val("done", longint'(bus.done), longint'(model_cnt == 1), 0);
      if (model_cnt == 0)
        check_val("lut_i_idle", longint'(bus.lut_i), 0, 0);
      else if (lut_chk && model_cnt > 1 && ((2 * ITER + 1 - model_cnt) % 2 == 0))
        check_val("lut_i_fetch", longint'(bus.lut_i), longint'((2 * ITER + 1 - model_cnt) / 2), 0);
      if (model_cnt == 1) begin
        if (sb.size() == 0) begin
          check_val("sb_empty", 1, 0, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.v) begin
            check_val("cos", longint'(bus.cos_out), e.c, TOL);
            check_val("sin", longint'(bus.sin_out), e.s, TOL);
          end
        end
      end
    end
  end

  task automatic wait_idle();
    for (int n = 0; n < 400; n++) begin
      if (model_cnt == 0 && sb.size() == 0) return;
      @(negedge clk);
    end
    check_val("timeout", 1, 0, 0);
  endtask

  task automatic run_op(input int a);
    wait_idle();
    bus.start    = 1'b1;
    bus.angle_in = a;
    @(negedge clk);
    bus.start    = 1'b0;
    wait_idle();
  endtask

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.angle_in = '0;
    repeat (3) @(negedge clk);
    check_val("rst_busy",  longint'(bus.busy), 0, 0);
    check_val("rst_done",  longint'(bus.done), 0, 0);
    check_val("rst_lut_i", longint'(bus.lut_i), 0, 0);
    check_val("rst_cos",   longint'(bus.cos_out), 0, 0);
    check_val("rst_sin",   longint'(bus.sin_out), 0, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op(0);
    run_op(30 * DEG);
    lut_chk = 1'b1;
    run_op(-45 * DEG);
    lut_chk = 1'b0;

    // 90 degrees, with extra start pulses while busy that must be ignored
    wait_idle();
    bus.start    = 1'b1;
    bus.angle_in = 90 * DEG;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.angle_in = 10 * DEG;
    repeat (5) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();

    run_op(150 * DEG);
    run_op(-150 * DEG);
    run_op(-90 * DEG);

    // start held high: back-to-back operations with a one-cycle idle gap
    wait_idle();
    bus.start    = 1'b1;
    bus.angle_in = 60 * DEG;
    repeat (40) @(negedge clk);
    bus.start = 1'b0;
    wait_idle();

    // reset during the ROT cycle of iteration 7 aborts without a done pulse
    bus.start    = 1'b1;
    bus.angle_in = 30 * DEG;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("abort_busy", longint'(bus.busy), 0, 0);
    check_val("abort_done", longint'(bus.done), 0, 0);
    check_val("abort_cos",  longint'(bus.cos_out), 0, 0);
    check_val("abort_sin",  longint'(bus.sin_out), 0, 0);
    repeat (2) @(negedge clk);
    check_val("abort_lut_i", longint'(bus.lut_i), 0, 0);
    rst = 1'b0;
    @(negedge clk);
    run_op(45 * DEG);
    run_op(-20 * DEG);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cordic_rot_ctrl.md
# cordic_rot_ctrl

Iterative CORDIC rotation-mode engine and sequencer for the θ–tanθ arctangent lookup table. It takes a signed angle in degrees (16.16 fixed point) and walks the iteration index through the LUT one step at a time. Each iteration applies a shift-add micro-rotation to x/y and subtracts the looked-up angle from the residual. It sits between the LUT and the trig consumers (waveform/phase logic) and outputs cos/sin in Q2.30.

## Interface
- ITER, 16, number of CORDIC iterations; legal range 1..21, since the LUT returns 0 above index 20.
- K_INIT, 652032874, initial x value: CORDIC gain compensation 0.6072529 × 2^30.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  request. Sampled only while idle; ignored while busy.
- angle_in  in  32  signed target angle in degrees: bits [31:16] integer, [15:0] fraction.
- busy  out  1  high from the cycle after start is accepted through the done cycle inclusive.
- done  out  1  one-cycle pulse; cos_out/sin_out are valid from this cycle.
- cos_out  out  32  signed Q2.30 cosine; held until the next done.
- sin_out  out  32  signed Q2.30 sine; held until the next done.
- lut_i  out  5  iteration index driven to the LUT.
- lut_xita  in  32  LUT angle for lut_i, registered one cycle after lut_i. Bit 31 is ignored and treated as 0.

## Operation
- FSM states: IDLE, FETCH, ROT, DONE.
- **IDLE**
  - On start=1, load x=K_INIT, y=0, z=angle_in (see Configuration), i=0; go to FETCH.
- **FETCH**
  - lut_i=i; the LUT registers xita at this edge; go to ROT.
- **ROT**
  - d=+1 if z≥0 (sign bit 0), else −1.
  - x'=x−d·(y>>>i); y'=y+d·(x>>>i); z'=z−d·{1'b0,lut_xita[30:0]}.
  - All arithmetic is 32-bit signed two's complement with arithmetic shifts and no saturation.
  - If i==ITER−1, go to DONE; else i=i+1 and go to FETCH.
- **DONE**
  - Register cos_out=x and sin_out=y (negated when the quadrant flag is set); done=1; go to IDLE.
- lut_i is driven as the current i in every state and is 0 in IDLE.
- Outputs change only on entry to DONE.
- Reset values: busy=0, done=0, lut_i=0, cos_out=0, sin_out=0. FSM returns to IDLE; x/y/z/i are cleared.
- Reset mid-operation aborts immediately with no done pulse; cos_out/sin_out are cleared to 0.
- start held high continuously: a new operation begins on the first IDLE cycle after DONE, one cycle gap.
- start during DONE is ignored, because busy is still high.
- Accuracy at ITER=16, |angle|≤90°: |error| ≤ 2^17 LSB (~1.2e-4) on each output.

## Timing
- start sampled at edge T. FETCH occupies cycle T+1; iteration k runs FETCH at T+1+2k and ROT at T+2+2k.
- done is high in cycle T+2·ITER+1; for ITER=16 that is 33 cycles after the start edge.
- Throughput: one result per 2·ITER+2 cycles with start held high.
- LUT read latency is fixed at exactly 1 cycle, and the controller consumes lut_xita only in ROT.

## Configuration
- Macro: CORDIC_ROT_CTRL_QUAD_EN.
- **Defined:** range extends to ±180° via quadrant pre-rotation at load.
  - angle_in > 90·2^16: z = angle_in − 180·2^16 and neg = 1.
  - angle_in < −90·2^16: z = angle_in + 180·2^16 and neg = 1.
  - Otherwise neg = 0.
  - In DONE, both outputs are negated when neg = 1.
- **Undefined:** z = angle_in directly, with no flag and no negation logic. Results are specified only for |angle_in| ≤ 90°; outside that, results are undefined but the FSM still completes normally.

## Test plan
- angle_in=0, ITER=16 → done at T+33; cos_out≈1073741824, sin_out≈0, both within 2^17.
- angle_in=30·2^16 (1966080) → cos_out≈929887697, sin_out≈536870912, within 2^17.
- angle_in=−45·2^16 (−2949120) → cos_out≈759250125, sin_out≈−759250125; lut_i steps 0..15 during FETCH cycles.
- angle_in=90·2^16 → cos_out≈0, sin_out≈1073741824. Pulse start again while busy → ignored, exactly one done.
- rst asserted in ROT of iteration 7 → immediately busy=0, done never pulses, outputs 0. A new start after release produces a normal result.
- CORDIC_ROT_CTRL_QUAD_EN defined, angle_in=150·2^16 (9830400) → cos_out≈−929887697, sin_out≈536870912. Same stimulus without the macro: no check on values, but done must occur at T+33.
